pattern_gen: RTL
================

Name: pattern_gen

Overview:
- Upstream source stage of the RGB path.
- Generates 640x480@60 VGA timing from the board clock: hsync, vsync, data-enable and pixel coordinates.
- Produces a 3-bit test-pattern colour per pixel, which feeds the colour-remap stage's rgb_i.
- Four selectable patterns, one animated. Mode changes are applied only at frame boundaries, so there is no tearing.

Parameters:
- CLK_DIV, 2, clk_i cycles per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- BAR_W, 80, vertical colour-bar width (pixels)
- BAR_H, 60, horizontal colour-bar height (lines)
- SCROLL_FRAMES, 1, frames per scroll step in mode 3; must be >= 1

Ports:
- clk_i, input, 1, system clock
- rst_i, input, 1, asynchronous reset, active-high
- mode_i, input, 2, pattern select; sampled at frame start
- hsync_o, output, 1, horizontal sync, active-low
- vsync_o, output, 1, vertical sync, active-low
- de_o, output, 1, high while the pixel is in the visible area
- col_o, output, 10, pixel column; 0..H_TOTAL-1
- row_o, output, 10, pixel row; 0..V_TOTAL-1
- rgb_o, output, 3, pattern colour to the remap stage; 0 when de_o is low
- frame_o, output, 1, one clk_i-cycle pulse when pixel (0,0) is presented

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800; V_TOTAL = 525.
- Reset values (asynchronous on rst_i high):
  - div, h, v, mode_q, scroll counters = 0
  - hsync_o = 1, vsync_o = 1
  - de_o = 0, rgb_o = 0, col_o = 0, row_o = 0, frame_o = 0
- Pixel enable:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_ce is high when div == CLK_DIV-1.
  - The first pix_ce occurs on the CLK_DIV-th rising edge after rst_i falls.
- Counters, advanced on pix_ce only:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1.
- Output stage, registered and updated only on pix_ce from the current (h,v); all outputs stay mutually aligned:
  - col_o = h, row_o = v
  - de_o = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync_o = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (columns 656..751)
  - vsync_o = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (rows 490..491)
  - rgb_o = pattern(mode_q, h, v) when de is high, else 3'b000
- Frame start, on pix_ce with h==0 and v==0:
  - mode_q <= mode_i; the new mode applies from this pixel onward.
  - frame_o pulses high for one clk_i cycle, the cycle the (0,0) outputs become visible.
- Patterns:
  - mode 0: vertical bars; colour = (h / BAR_W) mod 8, so col 0-79 -> 0 ... col 560-639 -> 7.
  - mode 1: horizontal bars; colour = (v / BAR_H) mod 8.
  - mode 2: checkerboard; colour = 3'b111 if h[5]^v[5], else 3'b000.
  - mode 3: scrolling bars; colour = ((h / BAR_W) + scroll_idx) mod 8.
  - Division is not permitted: use bar counters that reset at line/frame start and step when the in-bar counter reaches BAR_W-1 or BAR_H-1.
- Scroll:
  - A frame counter counts frame starts 0..SCROLL_FRAMES-1.
  - At wrap, scroll_idx (3 bits) increments mod 8.
  - scroll_idx is updated at the frame start and takes effect on the first pixel of the new frame.
- Boundary conditions:
  - mode_i changes mid-frame are ignored until the next frame start.
  - rst_i asserted mid-line returns all state and outputs to reset values immediately; after release, timing restarts at pixel (0,0).
  - Between pix_ce pulses, all outputs hold their values.

Decomposition:
- Package vga_pkg holds:
  - timing constants (defaults above, H_TOTAL, V_TOTAL)
  - mode encodings: MODE_VBAR=0, MODE_HBAR=1, MODE_CHECK=2, MODE_SCROLL=3
  - colour constants for black and white
- Sub-module vga_timing contains:
  - div counter, h/v counters, pix_ce
  - raw sync/de decode and the frame-start strobe
- pattern_gen instantiates vga_timing and adds pattern logic, the mode register and the output register.

Test Plan:
- Reset release, mode_i=0, CLK_DIV=2 -> first pix_ce on edge 2: col_o=0, row_o=0, de_o=1, rgb_o=000, frame_o=1 for one cycle.
- Run one line, mode 0 -> rgb_o=001 at col 80, 111 at col 639; de_o=0 and rgb_o=000 at col 640; hsync_o low for cols 656..751 (exactly 96 pixels).
- Run one full frame -> vsync_o low for rows 490..491 only; next frame_o exactly 840000 clk_i cycles after the first.
- mode_i 0->2 at row 100 -> rest of frame stays bars; next frame: (col 32, row 0)=111, (col 32, row 32)=000, (col 0, row 0)=000.
- mode 3, SCROLL_FRAMES=1 -> frame 0 col 0 = 000, frame 1 col 0 = 001, frame 8 col 0 = 000 (wrap).
- rst_i pulsed high at col 300, row 200 -> outputs immediately at reset values (hsync_o=1, de_o=0); after release the sequence restarts at (0,0) as in scenario 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pattern mode encodings and colour constants
// for the pattern generator and its timing core.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV       = 2;
    localparam int unsigned VGA_H_ACTIVE      = 640;
    localparam int unsigned VGA_H_FP          = 16;
    localparam int unsigned VGA_H_SYNC        = 96;
    localparam int unsigned VGA_H_BP          = 48;
    localparam int unsigned VGA_V_ACTIVE      = 480;
    localparam int unsigned VGA_V_FP          = 10;
    localparam int unsigned VGA_V_SYNC        = 2;
    localparam int unsigned VGA_V_BP          = 33;
    localparam int unsigned VGA_H_TOTAL       = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL       = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_BAR_W         = 80;
    localparam int unsigned VGA_BAR_H         = 60;
    localparam int unsigned VGA_SCROLL_FRAMES = 1;

    localparam int unsigned COORD_W = 10;

    typedef enum logic [1:0] {
        MODE_VBAR   = 2'd0,
        MODE_HBAR   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

endpackage

// File: rtl/vga_timing.sv
// VGA timing core: pixel-rate enable, h/v counters, raw sync/de decode and
// frame/line boundary strobes, all relative to the current (h,v).
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               pix_ce_o,
    output logic [COORD_W-1:0] h_o,
    output logic [COORD_W-1:0] v_o,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               frame_start_o,
    output logic               line_end_o,
    output logic               frame_end_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               pix_ce, line_end, frame_end;

    always_comb begin
        pix_ce    = (div_q == DIV_LAST);
        div_d     = pix_ce ? '0 : div_q + 1'b1;
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        h_d       = h_q;
        v_d       = v_q;
        if (pix_ce) begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign pix_ce_o      = pix_ce;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign de_o          = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o       = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_o       = !((v_q >= VS_START) && (v_q < VS_END));
    assign frame_start_o = pix_ce && (h_q == '0) && (v_q == '0);
    assign line_end_o    = line_end;
    assign frame_end_o   = frame_end;

endmodule

// File: rtl/pattern_gen.sv
// VGA test-pattern source: four selectable patterns (one scrolling), mode
// latched at frame start, all outputs registered on the pixel enable.
module pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV       = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE      = VGA_H_ACTIVE,
    parameter int unsigned H_FP          = VGA_H_FP,
    parameter int unsigned H_SYNC        = VGA_H_SYNC,
    parameter int unsigned H_BP          = VGA_H_BP,
    parameter int unsigned V_ACTIVE      = VGA_V_ACTIVE,
    parameter int unsigned V_FP          = VGA_V_FP,
    parameter int unsigned V_SYNC        = VGA_V_SYNC,
    parameter int unsigned V_BP          = VGA_V_BP,
    parameter int unsigned BAR_W         = VGA_BAR_W,
    parameter int unsigned BAR_H         = VGA_BAR_H,
    parameter int unsigned SCROLL_FRAMES = VGA_SCROLL_FRAMES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         mode_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o,
    output logic [2:0]         rgb_o,
    output logic               frame_o
);

    localparam int unsigned FCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(SCROLL_FRAMES - 1);
    localparam logic [COORD_W-1:0] HBAR_LAST = COORD_W'(BAR_W - 1);
    localparam logic [COORD_W-1:0] VBAR_LAST = COORD_W'(BAR_H - 1);

    logic               pix_ce, de_raw, hsync_raw, vsync_raw;
    logic               frame_start, line_end, frame_end;
    logic [COORD_W-1:0] h, v;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pix_ce_o      (pix_ce),
        .h_o           (h),
        .v_o           (v),
        .de_o          (de_raw),
        .hsync_o       (hsync_raw),
        .vsync_o       (vsync_raw),
        .frame_start_o (frame_start),
        .line_end_o    (line_end),
        .frame_end_o   (frame_end)
    );

    logic [1:0]         mode_q, mode_d;
    logic [COORD_W-1:0] hbar_cnt_q, hbar_cnt_d, vbar_cnt_q, vbar_cnt_d;
    logic [2:0]         hbar_idx_q, hbar_idx_d, vbar_idx_q, vbar_idx_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [2:0]         scroll_q, scroll_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, frame_q, frame_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [2:0]         rgb_q, rgb_d, pat;

    // Bar counters track h/v so bar index = coordinate / bar size without a divider.
    always_comb begin
        hbar_cnt_d = hbar_cnt_q;
        hbar_idx_d = hbar_idx_q;
        vbar_cnt_d = vbar_cnt_q;
        vbar_idx_d = vbar_idx_q;
        fcnt_d     = fcnt_q;
        scroll_d   = scroll_q;
        if (pix_ce) begin
            if (line_end) begin
                hbar_cnt_d = '0;
                hbar_idx_d = '0;
                if (frame_end) begin
                    vbar_cnt_d = '0;
                    vbar_idx_d = '0;
                end else if (vbar_cnt_q == VBAR_LAST) begin
                    vbar_cnt_d = '0;
                    vbar_idx_d = vbar_idx_q + 1'b1;
                end else begin
                    vbar_cnt_d = vbar_cnt_q + 1'b1;
                end
            end else if (hbar_cnt_q == HBAR_LAST) begin
                hbar_cnt_d = '0;
                hbar_idx_d = hbar_idx_q + 1'b1;
            end else begin
                hbar_cnt_d = hbar_cnt_q + 1'b1;
            end
            // Advancing on the last pixel makes the new offset visible from (0,0).
            if (frame_end) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d   = '0;
                    scroll_d = scroll_q + 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_d = frame_start ? mode_i : mode_q;
        pat    = COL_BLACK;
        case (mode_e'(mode_d))
            MODE_VBAR:   pat = hbar_idx_q;
            MODE_HBAR:   pat = vbar_idx_q;
            MODE_CHECK:  pat = (h[5] ^ v[5]) ? COL_WHITE : COL_BLACK;
            MODE_SCROLL: pat = hbar_idx_q + scroll_q;
            default:     pat = COL_BLACK;
        endcase
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        col_d   = col_q;
        row_d   = row_q;
        rgb_d   = rgb_q;
        frame_d = frame_start;
        if (pix_ce) begin
            hsync_d = hsync_raw;
            vsync_d = vsync_raw;
            de_d    = de_raw;
            col_d   = h;
            row_d   = v;
            rgb_d   = de_raw ? pat : COL_BLACK;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q     <= '0;
            hbar_cnt_q <= '0;
            hbar_idx_q <= '0;
            vbar_cnt_q <= '0;
            vbar_idx_q <= '0;
            fcnt_q     <= '0;
            scroll_q   <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            rgb_q      <= COL_BLACK;
            frame_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            hbar_cnt_q <= hbar_cnt_d;
            hbar_idx_q <= hbar_idx_d;
            vbar_cnt_q <= vbar_cnt_d;
            vbar_idx_q <= vbar_idx_d;
            fcnt_q     <= fcnt_d;
            scroll_q   <= scroll_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rgb_q      <= rgb_d;
            frame_q    <= frame_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;
    assign col_o   = col_q;
    assign row_o   = row_q;
    assign rgb_o   = rgb_q;
    assign frame_o = frame_q;

endmodule
